// File: rtl/m_seq_gen.sv
// Fibonacci LFSR m-sequence generator with seed load, zero-seed rejection
// and on-line measurement of the period between reference-seed visits.
module m_seq_gen #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
  parameter logic [WIDTH-1:0] SEED  = 4'b0110,
  parameter int               CNT_W = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic             out,
  output logic             out_vld,
  output logic [WIDTH-1:0] shift,
  output logic             wrap,
  output logic [CNT_W-1:0] period,
  output logic             seed_err
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("m_seq_gen: WIDTH must be in 2..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("m_seq_gen: SEED must be non-zero");
  end
  if (TAPS[0] == 1'b0) begin : g_bad_taps
    $error("m_seq_gen: TAPS[0] must be 1");
  end

  logic [WIDTH-1:0] ref_seed;
  logic [CNT_W-1:0] cnt;
  logic             fb;
  logic [WIDTH-1:0] next_shift;

  always_comb begin
    fb         = ^(shift & TAPS);
    next_shift = {fb, shift[WIDTH-1:1]};
  end

  // Priority: load over en over hold. A zero seed falls back to SEED so the
  // register can never enter the all-zero lock-up state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift    <= SEED;
      ref_seed <= SEED;
      out      <= 1'b0;
      out_vld  <= 1'b0;
      wrap     <= 1'b0;
      period   <= '0;
      cnt      <= '0;
      seed_err <= 1'b0;
    end else if (load) begin
      if (seed != '0) begin
        shift    <= seed;
        ref_seed <= seed;
        seed_err <= 1'b0;
      end else begin
        shift    <= SEED;
        ref_seed <= SEED;
        seed_err <= 1'b1;
      end
      cnt     <= '0;
      out_vld <= 1'b0;
      wrap    <= 1'b0;
    end else if (en) begin
      shift    <= next_shift;
      out      <= shift[0];
      out_vld  <= 1'b1;
      seed_err <= 1'b0;
      if (next_shift == ref_seed) begin
        wrap   <= 1'b1;
        period <= cnt + CNT_W'(1);
        cnt    <= '0;
      end else begin
        wrap <= 1'b0;
        if (cnt != '1) cnt <= cnt + CNT_W'(1);
      end
    end else begin
      out_vld  <= 1'b0;
      wrap     <= 1'b0;
      seed_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m_seq_gen.sv
// Directed bench for m_seq_gen: step responses go through expected queues
// checked by a monitor on out_vld; control responses are checked inline.
module tb_m_seq_gen;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       en, load;
  logic [3:0] seed;
  logic       out, out_vld, wrap, seed_err;
  logic [3:0] shift;
  logic [31:0] period;

  logic       en5, load5;
  logic [3:0] seed5;
  logic       out5, out_vld5, wrap5, seed_err5;
  logic [3:0] shift5;
  logic [31:0] period5;

  logic [37:0] exp_q[$];
  logic [37:0] exp5_q[$];
  int checks = 0;
  int errors = 0;

  logic [3:0] sh_tbl [15] = '{4'b0011, 4'b1001, 4'b0100, 4'b0010, 4'b0001,
                              4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111,
                              4'b1011, 4'b0101, 4'b1010, 4'b1101, 4'b0110};
  logic       out_tbl [15] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 1};
  logic [3:0] sh5_tbl [7] = '{4'b1000, 4'b0100, 4'b1010, 4'b0101, 4'b0010,
                              4'b0001, 4'b1000};
  logic       out5_tbl [7] = '{1, 0, 0, 0, 1, 0, 1};

  m_seq_gen dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .load(load), .seed(seed),
    .out(out), .out_vld(out_vld), .shift(shift), .wrap(wrap), .period(period),
    .seed_err(seed_err)
  );

  m_seq_gen #(.WIDTH(4), .TAPS(4'b0101), .SEED(4'b0110), .CNT_W(32)) dut5 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en5), .load(load5), .seed(seed5),
    .out(out5), .out_vld(out_vld5), .shift(shift5), .wrap(wrap5), .period(period5),
    .seed_err(seed_err5)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [37:0] pk(logic o, logic [3:0] sh, logic w, logic [31:0] p);
    return {o, sh, w, p};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // driver: inputs change 1 time unit after the rising edge
  task automatic cycle(logic e, logic l, logic [3:0] s);
    en = e; load = l; seed = s;
    @(posedge sys_clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge sys_clk) begin
    if (out_vld) begin
      if (exp_q.size() == 0) chk("unexpected_vld", 64'd1, 64'd0);
      else chk("step", {26'd0, out, shift, wrap, period}, {26'd0, exp_q.pop_front()});
    end
    if (out_vld5) begin
      if (exp5_q.size() == 0) chk("unexpected_vld5", 64'd1, 64'd0);
      else chk("step5", {26'd0, out5, shift5, wrap5, period5}, {26'd0, exp5_q.pop_front()});
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    en = 0; load = 0; seed = 0;
    en5 = 0; load5 = 0; seed5 = 0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    #1;
    chk("rst_shift", 64'(shift), 64'h6);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_wrap", 64'(wrap), 64'd0);
    chk("rst_period", 64'(period), 64'd0);
    chk("rst_seed_err", 64'(seed_err), 64'd0);

    // 45 default steps: three full periods, wrap on steps 15, 30, 45
    for (int i = 0; i < 45; i++) begin
      exp_q.push_back(pk(out_tbl[i % 15], sh_tbl[i % 15], (i % 15) == 14,
                         (i >= 14) ? 32'd15 : 32'd0));
      cycle(1, 0, 4'd0);
    end

    // zero-seed load is rejected and restores SEED
    exp_q.push_back(pk(1'b0, 4'b0011, 1'b0, 32'd15));
    cycle(1, 0, 4'd0);
    cycle(0, 1, 4'd0);
    chk("zload_err", 64'(seed_err), 64'd1);
    chk("zload_shift", 64'(shift), 64'h6);
    chk("zload_vld", 64'(out_vld), 64'd0);
    chk("zload_out_hold", 64'(out), 64'd0);
    exp_q.push_back(pk(1'b0, 4'b0011, 1'b0, 32'd15));
    cycle(1, 0, 4'd0);
    chk("zload_err_clr", 64'(seed_err), 64'd0);

    // en 1,0,0 then load+en together
    exp_q.push_back(pk(1'b1, 4'b1001, 1'b0, 32'd15));
    cycle(1, 0, 4'd0);
    cycle(0, 0, 4'd0);
    chk("hold1_shift", 64'(shift), 64'h9);
    chk("hold1_vld", 64'(out_vld), 64'd0);
    cycle(0, 0, 4'd0);
    chk("hold2_shift", 64'(shift), 64'h9);
    chk("hold2_out", 64'(out), 64'd1);
    cycle(1, 1, 4'b1100);
    chk("ldens_shift", 64'(shift), 64'hC);
    chk("ldens_vld", 64'(out_vld), 64'd0);
    chk("ldens_err", 64'(seed_err), 64'd0);
    exp_q.push_back(pk(1'b0, 4'b1110, 1'b0, 32'd15));
    cycle(1, 0, 4'd0);

    // asynchronous reset away from any clock edge, with out_vld high
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("arst_shift", 64'(shift), 64'h6);
    chk("arst_period", 64'(period), 64'd0);
    chk("arst_vld", 64'(out_vld), 64'd0);
    chk("arst_wrap", 64'(wrap), 64'd0);
    chk("arst_err", 64'(seed_err), 64'd0);
    chk("arst_out", 64'(out), 64'd0);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // TAPS=0101 instance: load 0001, period 6 relative to the loaded seed
    en5 = 0; load5 = 1; seed5 = 4'b0001;
    cycle(0, 0, 4'd0);
    load5 = 0;
    chk("t5_load_shift", 64'(shift5), 64'h1);
    for (int i = 0; i < 7; i++) begin
      exp5_q.push_back(pk(out5_tbl[i], sh5_tbl[i], i == 5, (i >= 5) ? 32'd6 : 32'd0));
      en5 = 1;
      cycle(0, 0, 4'd0);
    end
    en5 = 0;
    cycle(0, 0, 4'd0);
    cycle(0, 0, 4'd0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("queue5_empty", 64'(exp5_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
